// File: rtl/core_mc.sv
// core_mc: multi-cycle 6502-subset sequencer (A/X/Y/P, imm/zp/abs, stores, JMP abs).
// Optional CORE_RDY_EN adds an rdy input that stretches read cycles.
module core_mc #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [7:0]  ZP_PAGE  = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   output logic        RW,
   output logic [15:0] AD,
   input  logic [7:0]  D_in,
`ifdef CORE_RDY_EN
   input  logic        rdy,
`endif
   output logic [7:0]  D_out,
   output logic        sync,
   output logic [7:0]  A_dbg,
   output logic [7:0]  X_dbg,
   output logic [7:0]  Y_dbg,
   output logic [7:0]  P_dbg
);

   typedef enum logic [4:0] {
      FETCH   = 5'b00001,
      DECODE  = 5'b00010,
      ADDR_LO = 5'b00100,
      ADDR_HI = 5'b01000,
      EXEC    = 5'b10000
   } state_t;

   typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ABS, M_JMP} mode_t;

   typedef enum logic [4:0] {
      K_NOP, K_LDA, K_LDX, K_LDY, K_STA, K_STX, K_STY, K_ADC, K_AND, K_ORA, K_EOR,
      K_TAX, K_TAY, K_TXA, K_TYA, K_INX, K_INY, K_DEX, K_DEY, K_CLC, K_SEC, K_JMP
   } kind_t;

   state_t      state_q, state_d;
   logic [15:0] pc;
   logic [7:0]  ir, lo, a, x, y;
   logic        n, v, z, c;
   logic [7:0]  data, op, src, dout, res;
   logic [15:0] ad;
   logic        rw, stall, pc_inc, pc_load, commit, is_store, set_nz;
   mode_t       mode;
   kind_t       kind;
   logic [7:0]  a_d, x_d, y_d;
   logic        n_d, v_d, z_d, c_d;
   logic [8:0]  sum9;

`ifdef CORE_RDY_EN
   // A stalled read keeps the byte that arrived on its first cycle, so the
   // address computed from it (and the value consumed) stays stable.
   logic       stalled;
   logic [7:0] din_hold;
   assign stall = !rdy && rw;
   assign data  = stalled ? din_hold : D_in;
   always_ff @(posedge clk) begin
      if (rst) begin
         stalled  <= 1'b0;
         din_hold <= 8'h00;
      end else if (stall) begin
         stalled <= 1'b1;
         if (!stalled) din_hold <= D_in;
      end else begin
         stalled <= 1'b0;
      end
   end
`else
   assign stall = 1'b0;
   assign data  = D_in;
`endif

   // In DECODE the opcode is still on the bus; afterwards it lives in IR.
   assign op = (state_q == DECODE) ? data : ir;

   always_comb begin
      kind = K_NOP;
      mode = M_IMP;
      case (op)
         8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49: mode = M_IMM;
         8'hA5, 8'hA6, 8'hA4, 8'h65, 8'h25, 8'h05, 8'h45,
         8'h85, 8'h86, 8'h84:                             mode = M_ZP;
         8'hAD, 8'hAE, 8'hAC, 8'h6D, 8'h2D, 8'h0D, 8'h4D,
         8'h8D, 8'h8E, 8'h8C:                             mode = M_ABS;
         8'h4C:                                           mode = M_JMP;
         default:                                         mode = M_IMP;
      endcase
      case (op)
         8'hA9, 8'hA5, 8'hAD: kind = K_LDA;
         8'hA2, 8'hA6, 8'hAE: kind = K_LDX;
         8'hA0, 8'hA4, 8'hAC: kind = K_LDY;
         8'h85, 8'h8D:        kind = K_STA;
         8'h86, 8'h8E:        kind = K_STX;
         8'h84, 8'h8C:        kind = K_STY;
         8'h69, 8'h65, 8'h6D: kind = K_ADC;
         8'h29, 8'h25, 8'h2D: kind = K_AND;
         8'h09, 8'h05, 8'h0D: kind = K_ORA;
         8'h49, 8'h45, 8'h4D: kind = K_EOR;
         8'hAA: kind = K_TAX;
         8'hA8: kind = K_TAY;
         8'h8A: kind = K_TXA;
         8'h98: kind = K_TYA;
         8'hE8: kind = K_INX;
         8'hC8: kind = K_INY;
         8'hCA: kind = K_DEX;
         8'h88: kind = K_DEY;
         8'h18: kind = K_CLC;
         8'h38: kind = K_SEC;
         8'h4C: kind = K_JMP;
         default: kind = K_NOP;
      endcase
   end

   assign is_store = (kind == K_STA) || (kind == K_STX) || (kind == K_STY);
   assign src      = (kind == K_STA) ? a : (kind == K_STX) ? x : y;
   assign sum9     = {1'b0, a} + {1'b0, data} + {8'h00, c};

   always_comb begin
      a_d = a; x_d = x; y_d = y;
      n_d = n; v_d = v; z_d = z; c_d = c;
      res = 8'h00;
      set_nz = 1'b1;
      case (kind)
         K_LDA: begin a_d = data; res = data; end
         K_LDX: begin x_d = data; res = data; end
         K_LDY: begin y_d = data; res = data; end
         K_ADC: begin
            a_d = sum9[7:0]; res = sum9[7:0]; c_d = sum9[8];
            v_d = (a[7] == data[7]) && (sum9[7] != a[7]);
         end
         K_AND: begin a_d = a & data; res = a & data; end
         K_ORA: begin a_d = a | data; res = a | data; end
         K_EOR: begin a_d = a ^ data; res = a ^ data; end
         K_TAX: begin x_d = a; res = a; end
         K_TAY: begin y_d = a; res = a; end
         K_TXA: begin a_d = x; res = x; end
         K_TYA: begin a_d = y; res = y; end
         K_INX: begin x_d = x + 8'd1; res = x + 8'd1; end
         K_INY: begin y_d = y + 8'd1; res = y + 8'd1; end
         K_DEX: begin x_d = x - 8'd1; res = x - 8'd1; end
         K_DEY: begin y_d = y - 8'd1; res = y - 8'd1; end
         K_CLC: begin c_d = 1'b0; set_nz = 1'b0; end
         K_SEC: begin c_d = 1'b1; set_nz = 1'b0; end
         default: set_nz = 1'b0;
      endcase
      if (set_nz) begin
         n_d = res[7];
         z_d = (res == 8'h00);
      end
   end

   assign commit = !stall && (((state_q == DECODE) && (mode == M_IMP)) || (state_q == EXEC));

   always_comb begin
      state_d = state_q;
      ad      = pc;
      rw      = 1'b1;
      dout    = 8'h00;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      case (state_q)
         FETCH: begin pc_inc = 1'b1; state_d = DECODE; end
         DECODE: begin
            if (mode == M_IMP) state_d = FETCH;
            else begin
               pc_inc  = 1'b1;
               state_d = (mode == M_IMM) ? EXEC : ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (mode == M_ZP) begin
               ad = {ZP_PAGE, data};
               if (is_store) begin rw = 1'b0; dout = src; state_d = FETCH; end
               else state_d = EXEC;
            end else begin
               pc_inc  = 1'b1;
               state_d = ADDR_HI;
            end
         end
         ADDR_HI: begin
            if (mode == M_JMP) begin pc_load = 1'b1; state_d = FETCH; end
            else begin
               ad = {data, lo};
               if (is_store) begin rw = 1'b0; dout = src; state_d = FETCH; end
               else state_d = EXEC;
            end
         end
         EXEC:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else if (!stall) state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC; ir <= 8'h00; lo <= 8'h00;
         a <= 8'h00; x <= 8'h00; y <= 8'h00;
         n <= 1'b0; v <= 1'b0; z <= 1'b0; c <= 1'b0;
      end else if (!stall) begin
         if (pc_load) pc <= {data, lo};
         else if (pc_inc) pc <= pc + 16'd1;
         if (state_q == DECODE) ir <= data;
         if (state_q == ADDR_LO) lo <= data;
         if (commit) begin
            a <= a_d; x <= x_d; y <= y_d;
            n <= n_d; v <= v_d; z <= z_d; c <= c_d;
         end
      end
   end

   // Reset forces a read so an interrupted store never reaches memory.
   assign RW    = rst ? 1'b1 : rw;
   assign D_out = rst ? 8'h00 : dout;
   assign AD    = ad;
   assign sync  = (state_q == FETCH);
   assign A_dbg = a;
   assign X_dbg = x;
   assign Y_dbg = y;
   assign P_dbg = {n, v, 1'b1, 3'b000, z, c};

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: vector table, hand sequences and a randomized instruction-level
// reference model for core_mc (RESET_PC=0200, ZP_PAGE=00).
module tb_core_mc;
   localparam logic [15:0] RPC = 16'h0200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RW, sync;
   logic [15:0] AD;
   logic [7:0]  D_in = 8'h00;
   logic [7:0]  D_out, A_dbg, X_dbg, Y_dbg, P_dbg;
`ifdef CORE_RDY_EN
   logic        rdy = 1'b1;
   logic [31:0] hold_mask = 32'h0;
`endif

   int checks = 0;
   int failures = 0;

   logic [7:0]  mem     [65536];
   logic [7:0]  ref_mem [65536];
   logic [15:0] tr_ad [20];
   logic        tr_rw [20];
   logic [7:0]  tr_do [20];
   logic [23:0] exp_q [$];
   logic [7:0]  pool [40];

   logic [7:0]  r_a, r_x, r_y;
   logic        r_n, r_v, r_z, r_c;
   logic [15:0] r_pc;

   core_mc #(.RESET_PC(RPC), .ZP_PAGE(8'h00)) dut (
      .clk(clk), .rst(rst), .RW(RW), .AD(AD), .D_in(D_in),
`ifdef CORE_RDY_EN
      .rdy(rdy),
`endif
      .D_out(D_out), .sync(sync),
      .A_dbg(A_dbg), .X_dbg(X_dbg), .Y_dbg(Y_dbg), .P_dbg(P_dbg)
   );

   always #5 clk = ~clk;

   // Bus memory: one-cycle read latency, write on RW=0.
   always @(posedge clk) begin
      D_in <= mem[AD];
      if (!RW) mem[AD] = D_out;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
   endtask

   task automatic put(input logic [15:0] addr, input logic [7:0] b);
      mem[addr] = b;
      ref_mem[addr] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rw", RW, 1);
      chk("rst_dout", D_out, 8'h00);
      rst = 1'b0;
      #1;
      chk("rel_sync", sync, 1);
      chk("rel_ad", AD, RPC);
      chk("rel_rw", RW, 1);
      chk("rel_a", A_dbg, 8'h00);
      chk("rel_x", X_dbg, 8'h00);
      chk("rel_y", Y_dbg, 8'h00);
      chk("rel_p", P_dbg, 8'h20);
   endtask

   // Entered in a FETCH cycle; returns the number of cycles until the next FETCH.
   task automatic step_instr(output int cyc);
      cyc = 0;
      do begin
`ifdef CORE_RDY_EN
         rdy = !hold_mask[cyc];
`endif
         #1;
         tr_ad[cyc] = AD;
         tr_rw[cyc] = RW;
         tr_do[cyc] = D_out;
         @(negedge clk);
         #1;
         cyc++;
      end while (!sync && cyc < 20);
`ifdef CORE_RDY_EN
      rdy = 1'b1;
`endif
      chk("step_sync", sync, 1);
   endtask

   function automatic int op_mode(input logic [7:0] o);
      case (o)
         8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49: return 1;
         8'hA5, 8'hA6, 8'hA4, 8'h65, 8'h25, 8'h05, 8'h45, 8'h85, 8'h86, 8'h84: return 2;
         8'hAD, 8'hAE, 8'hAC, 8'h6D, 8'h2D, 8'h0D, 8'h4D, 8'h8D, 8'h8E, 8'h8C: return 3;
         8'h4C: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_st(input logic [7:0] o);
      return (o == 8'h85) || (o == 8'h86) || (o == 8'h84) ||
             (o == 8'h8D) || (o == 8'h8E) || (o == 8'h8C);
   endfunction

   task automatic ref_write(input logic [15:0] ea, input logic [7:0] val);
      ref_mem[ea] = val;
      exp_q.push_back({ea, val});
   endtask

   // Instruction-level model: executes one instruction at r_pc.
   task automatic ref_exec(output int cyc);
      logic [7:0]  o, b1, b2, m, res;
      logic [15:0] ea;
      int md, len, sum;
      bit nz;
      o  = ref_mem[r_pc];
      b1 = ref_mem[r_pc + 16'd1];
      b2 = ref_mem[r_pc + 16'd2];
      md = op_mode(o);
      ea = 16'h0000;
      m  = b1;
      case (md)
         1: begin len = 2; cyc = 3; end
         2: begin len = 2; ea = {8'h00, b1}; cyc = is_st(o) ? 3 : 4; end
         3: begin len = 3; ea = {b2, b1};    cyc = is_st(o) ? 4 : 5; end
         4: begin len = 3; cyc = 4; end
         default: begin len = 1; cyc = 2; end
      endcase
      if (md == 2 || md == 3) m = ref_mem[ea];
      nz = 1'b1;
      res = 8'h00;
      case (o)
         8'hA9, 8'hA5, 8'hAD: begin r_a = m; res = m; end
         8'hA2, 8'hA6, 8'hAE: begin r_x = m; res = m; end
         8'hA0, 8'hA4, 8'hAC: begin r_y = m; res = m; end
         8'h85, 8'h8D: begin ref_write(ea, r_a); nz = 1'b0; end
         8'h86, 8'h8E: begin ref_write(ea, r_x); nz = 1'b0; end
         8'h84, 8'h8C: begin ref_write(ea, r_y); nz = 1'b0; end
         8'h69, 8'h65, 8'h6D: begin
            sum = int'(r_a) + int'(m) + (r_c ? 1 : 0);
            res = sum[7:0];
            r_c = (sum > 255);
            r_v = (((r_a ^ res) & (m ^ res) & 8'h80) != 8'h00);
            r_a = res;
         end
         8'h29, 8'h25, 8'h2D: begin r_a = r_a & m; res = r_a; end
         8'h09, 8'h05, 8'h0D: begin r_a = r_a | m; res = r_a; end
         8'h49, 8'h45, 8'h4D: begin r_a = r_a ^ m; res = r_a; end
         8'hAA: begin r_x = r_a; res = r_a; end
         8'hA8: begin r_y = r_a; res = r_a; end
         8'h8A: begin r_a = r_x; res = r_x; end
         8'h98: begin r_a = r_y; res = r_y; end
         8'hE8: begin r_x = r_x + 8'd1; res = r_x; end
         8'hC8: begin r_y = r_y + 8'd1; res = r_y; end
         8'hCA: begin r_x = r_x - 8'd1; res = r_x; end
         8'h88: begin r_y = r_y - 8'd1; res = r_y; end
         8'h18: begin r_c = 1'b0; nz = 1'b0; end
         8'h38: begin r_c = 1'b1; nz = 1'b0; end
         default: nz = 1'b0;
      endcase
      if (nz) begin
         r_n = res[7];
         r_z = (res == 8'h00);
      end
      r_pc = (md == 4) ? {b2, b1} : r_pc + 16'(len);
   endtask

   typedef struct {
      logic [7:0] a0;
      logic       cin;
      logic [7:0] op;
      logic [7:0] m;
      logic [7:0] exp_a;
      logic [7:0] exp_p;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int cyc, ecyc;
      logic [7:0]  o;
      logic [15:0] pg;
      logic [23:0] w;

      vecs[0] = '{8'h05, 1'b0, 8'h69, 8'hFF, 8'h04, 8'h21};
      vecs[1] = '{8'h7F, 1'b0, 8'h69, 8'h01, 8'h80, 8'hE0};
      vecs[2] = '{8'h80, 1'b1, 8'h69, 8'h80, 8'h01, 8'h61};
      vecs[3] = '{8'hFF, 1'b1, 8'h69, 8'h00, 8'h00, 8'h23};
      vecs[4] = '{8'hF0, 1'b0, 8'h29, 8'h3C, 8'h30, 8'h20};
      vecs[5] = '{8'hF0, 1'b1, 8'h09, 8'h0F, 8'hFF, 8'hA1};
      vecs[6] = '{8'hAA, 1'b0, 8'h49, 8'hAA, 8'h00, 8'h22};
      vecs[7] = '{8'h00, 1'b1, 8'h29, 8'hFF, 8'h00, 8'h23};
      pool = '{8'hA9, 8'hA5, 8'hAD, 8'hA2, 8'hA6, 8'hAE, 8'hA0, 8'hA4, 8'hAC, 8'h85,
               8'h8D, 8'h86, 8'h8E, 8'h84, 8'h8C, 8'h69, 8'h65, 8'h6D, 8'h29, 8'h25,
               8'h2D, 8'h09, 8'h05, 8'h0D, 8'h49, 8'h45, 8'h4D, 8'hAA, 8'hA8, 8'h8A,
               8'h98, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'h18, 8'h38, 8'hEA, 8'h02, 8'hFF};

      // LDA #05 ; ADC #FF
      clear_mem();
      put(16'h0200, 8'hA9); put(16'h0201, 8'h05); put(16'h0202, 8'h69); put(16'h0203, 8'hFF);
      do_reset();
      step_instr(cyc); chk("lda_imm_cyc", cyc, 3);
      step_instr(cyc); chk("adc_imm_cyc", cyc, 3);
      chk("adc_a", A_dbg, 8'h04);
      chk("adc_p", P_dbg, 8'h21);
      chk("adc_pc", AD, 16'h0204);

      // LDA #a0 ; CLC/SEC ; op #m
      for (int i = 0; i < 8; i++) begin
         clear_mem();
         put(16'h0200, 8'hA9); put(16'h0201, vecs[i].a0);
         put(16'h0202, vecs[i].cin ? 8'h38 : 8'h18);
         put(16'h0203, vecs[i].op); put(16'h0204, vecs[i].m);
         do_reset();
         step_instr(cyc);
         step_instr(cyc); chk("vec_flag_cyc", cyc, 2);
         step_instr(cyc); chk("vec_alu_cyc", cyc, 3);
         chk("vec_a", A_dbg, vecs[i].exp_a);
         chk("vec_p", P_dbg, vecs[i].exp_p);
      end

      // LDA #3C ; STA 10 ; LDX 10
      clear_mem();
      put(16'h0200, 8'hA9); put(16'h0201, 8'h3C); put(16'h0202, 8'h85); put(16'h0203, 8'h10);
      put(16'h0204, 8'hA6); put(16'h0205, 8'h10);
      do_reset();
      step_instr(cyc);
      step_instr(cyc); chk("sta_zp_cyc", cyc, 3);
      chk("sta_zp_rw", tr_rw[2], 0);
      chk("sta_zp_ad", tr_ad[2], 16'h0010);
      chk("sta_zp_do", tr_do[2], 8'h3C);
      chk("sta_zp_do_idle", tr_do[1], 8'h00);
      chk("sta_zp_mem", mem[16'h0010], 8'h3C);
      step_instr(cyc); chk("ldx_zp_cyc", cyc, 4);
      chk("ldx_zp_rd", {tr_rw[2], tr_ad[2]}, {1'b1, 16'h0010});
      chk("ldx_zp_x", X_dbg, 8'h3C);

      // JMP 8000 ; LDA 1234 ; unknown 02
      clear_mem();
      put(16'h0200, 8'h4C); put(16'h0201, 8'h00); put(16'h0202, 8'h80);
      put(16'h8000, 8'hAD); put(16'h8001, 8'h34); put(16'h8002, 8'h12); put(16'h8003, 8'h02);
      put(16'h1234, 8'h5A);
      do_reset();
      step_instr(cyc); chk("jmp_cyc", cyc, 4);
      chk("jmp_pc", AD, 16'h8000);
      step_instr(cyc); chk("lda_abs_cyc", cyc, 5);
      chk("lda_abs_rd", {tr_rw[3], tr_ad[3]}, {1'b1, 16'h1234});
      chk("lda_abs_a", A_dbg, 8'h5A);
      step_instr(cyc); chk("nop02_cyc", cyc, 2);
      chk("nop02_pc", AD, 16'h8004);
      chk("nop02_p", P_dbg, 8'h20);

      // LDX #FF ; INX ; DEY ; LDA #81 ; TAY ; TXA
      clear_mem();
      put(16'h0200, 8'hA2); put(16'h0201, 8'hFF); put(16'h0202, 8'hE8); put(16'h0203, 8'h88);
      put(16'h0204, 8'hA9); put(16'h0205, 8'h81); put(16'h0206, 8'hA8); put(16'h0207, 8'h8A);
      do_reset();
      step_instr(cyc); chk("ldx_p", P_dbg, 8'hA0);
      step_instr(cyc); chk("inx_cyc", cyc, 2);
      chk("inx_wrap_x", X_dbg, 8'h00);
      chk("inx_wrap_p", P_dbg, 8'h22);
      step_instr(cyc); chk("dey_y", Y_dbg, 8'hFF);
      chk("dey_p", P_dbg, 8'hA0);
      step_instr(cyc);
      step_instr(cyc); chk("tay_y", Y_dbg, 8'h81);
      step_instr(cyc); chk("txa_a", A_dbg, 8'h00);
      chk("txa_p", P_dbg, 8'h22);

      // Reset landing on the write cycle of STA abs must suppress the write
      clear_mem();
      put(16'h0200, 8'hA9); put(16'h0201, 8'h3C);
      put(16'h0202, 8'h8D); put(16'h0203, 8'h00); put(16'h0204, 8'h31);
      do_reset();
      step_instr(cyc);
      repeat (3) @(negedge clk);
      #1;
      chk("abort_pre_rw", {RW, AD}, {1'b0, 16'h3100});
      rst = 1'b1;
      #1;
      chk("abort_rw", RW, 1);
      chk("abort_dout", D_out, 8'h00);
      do_reset();
      chk("abort_mem", mem[16'h3100], 8'h00);

`ifdef CORE_RDY_EN
      // LDA 1234 with three wait states in ADDR_HI ; STA 3100 with rdy low on its write
      clear_mem();
      put(16'h0200, 8'hAD); put(16'h0201, 8'h34); put(16'h0202, 8'h12);
      put(16'h0203, 8'h8D); put(16'h0204, 8'h00); put(16'h0205, 8'h31);
      put(16'h1234, 8'h77);
      do_reset();
      hold_mask = 32'b111000;
      step_instr(cyc); chk("rdy_lda_cyc", cyc, 8);
      for (int k = 3; k < 7; k++) chk("rdy_hold_ad", tr_ad[k], 16'h1234);
      chk("rdy_lda_a", A_dbg, 8'h77);
      hold_mask = 32'b1000;
      step_instr(cyc); chk("rdy_sta_cyc", cyc, 4);
      chk("rdy_sta_rw", tr_rw[3], 0);
      chk("rdy_sta_mem", mem[16'h3100], 8'h77);
      hold_mask = 32'h0;
`endif

      // Random programs against the instruction-level model
      for (int round = 0; round < 4; round++) begin
         clear_mem();
         exp_q.delete();
         for (int i = 0; i < 64; i++) put(16'(i), 8'($urandom_range(0, 255)));
         for (int i = 0; i < 256; i++) put(16'h3000 + 16'(i), 8'($urandom_range(0, 255)));
         pg = RPC;
         for (int i = 0; i < 60; i++) begin
            o = pool[$urandom_range(0, 39)];
            put(pg, o);
            case (op_mode(o))
               1: begin put(pg + 16'd1, 8'($urandom_range(0, 255))); pg = pg + 16'd2; end
               2: begin put(pg + 16'd1, 8'($urandom_range(0, 63)));  pg = pg + 16'd2; end
               3: begin
                  put(pg + 16'd1, 8'($urandom_range(0, 255)));
                  put(pg + 16'd2, 8'h30);
                  pg = pg + 16'd3;
               end
               default: pg = pg + 16'd1;
            endcase
         end
         do_reset();
         r_a = 8'h00; r_x = 8'h00; r_y = 8'h00;
         r_n = 1'b0; r_v = 1'b0; r_z = 1'b0; r_c = 1'b0;
         r_pc = RPC;
         for (int i = 0; i < 60; i++) begin
            ref_exec(ecyc);
            step_instr(cyc);
            chk("rnd_cyc", cyc, ecyc);
            for (int k = 0; k < cyc; k++) begin
               if (!tr_rw[k]) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rnd_wr_unexpected actual=%h required=none", tr_ad[k]);
                  end else begin
                     w = exp_q.pop_front();
                     chk("rnd_wr", {8'h00, tr_ad[k], tr_do[k]}, {8'h00, w});
                  end
               end
            end
            chk("rnd_a", A_dbg, r_a);
            chk("rnd_x", X_dbg, r_x);
            chk("rnd_y", Y_dbg, r_y);
            chk("rnd_p", P_dbg, {r_n, r_v, 1'b1, 3'b000, r_z, r_c});
            chk("rnd_pc", AD, r_pc);
         end
         chk("rnd_wr_left", exp_q.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
